clock_divider_prog: RTL

CLOCK_DIVIDER_PROG -- requirements
Module: clock_divider_prog

---
 rtl/fm_clk_pkg.sv | 18 +
 rtl/clock_divider_chan.sv | 97 +++++++++
 rtl/clock_divider_prog.sv | 78 +++++++
 3 files changed

// File: rtl/fm_clk_pkg.sv
// Shared constants and types for the programmable clock divider.
// Latency: n/a (declarations only); backpressure: n/a.
package fm_clk_pkg;

    localparam int unsigned MIN_DIV = 2;

    typedef enum logic [1:0] {
        EV_HOLD,
        EV_COUNT,
        EV_WRAP,
        EV_SYNC
    } chan_ev_e;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_divider_chan.sv
// One divider channel: counter, active/pending divisor, registered clk_o and tick.
// Latency: outputs registered, 1 cycle; backpressure: pending flag blocks new writes until a wrap or sync.
module clock_divider_chan
    import fm_clk_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             pending,
    output logic             clk_o,
    output logic             tick
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] half_m1;
    chan_ev_e         ev;

    always_comb begin
        ev = EV_HOLD;
        if (sync) begin
            ev = EV_SYNC;
        end else if (en) begin
            ev = (cnt_q == div_q - ONE) ? EV_WRAP : EV_COUNT;
        end
    end

    assign half_m1 = (div_q >> 1) - ONE;

    // D only changes at counter 0 with clk_o rising, so no phase is ever cut short.
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        pdiv_d = pdiv_q;
        pend_d = pend_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        case (ev)
            EV_SYNC, EV_WRAP: begin
                cnt_d  = '0;
                clk_d  = 1'b1;
                tick_d = (ev == EV_WRAP);
                if (pend_q) begin
                    div_d  = pdiv_q;
                    pend_d = 1'b0;
                end
            end
            EV_COUNT: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == half_m1) begin
                    clk_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (wr_vld) begin
            pdiv_d = wr_dat;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            div_q  <= RST_DIV;
            pdiv_q <= RST_DIV;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign pending = pend_q;
    assign clk_o   = clk_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock divider with per-channel divisor write port.
// Latency: clk_o/tick/div_err registered, 1 cycle; backpressure: div_ready low while the target channel has a pending divisor.
module clock_divider_prog
    import fm_clk_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNELS-1:0]              en,
    input  logic                             sync,
    input  logic                             div_valid,
    input  logic [sel_width(CHANNELS)-1:0]   div_ch,
    input  logic [WIDTH-1:0]                 div_value,
    output logic                             div_ready,
    output logic                             div_err,
    output logic [CHANNELS-1:0]              clk_o,
    output logic [CHANNELS-1:0]              tick
);

    localparam int unsigned CH_W  = sel_width(CHANNELS);
    localparam int unsigned SEL_N = 1 << CH_W;

    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] wr_vld;
    logic [SEL_N-1:0]    busy;
    logic                accept;
    logic                legal;
    logic                err_d, err_q;

    // Selects past the last channel read as permanently busy, so they are never accepted.
    for (genvar k = 0; k < SEL_N; k++) begin : g_busy
        if (k < CHANNELS) begin : g_real
            assign busy[k] = pending[k];
        end else begin : g_oor
            assign busy[k] = 1'b1;
        end
    end

    always_comb begin
        div_ready = !busy[div_ch];
        accept    = div_valid && div_ready;
        legal     = (div_value >= WIDTH'(MIN_DIV));
        err_d     = accept && !legal;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign wr_vld[i] = accept && legal && (div_ch == CH_W'(i));

        clock_divider_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (en[i]),
            .sync    (sync),
            .wr_vld  (wr_vld[i]),
            .wr_dat  (div_value),
            .pending (pending[i]),
            .clk_o   (clk_o[i]),
            .tick    (tick[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign div_err = err_q;

endmodule
